// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer sharing one SPI memory engine between the CPU (port 0) and debug loader (port 1).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
//
// state   | meaning
// IDLE    | sample requests, latch winner's operands, set its gnt
// ISSUE   | operands presented; mem_start rises on the next cycle
// WAIT    | mem_start held until mem_done, then done pulse
// RELEASE | gnt held until the engine drops mem_done
module mem_arbiter #(
  parameter int ADDR_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [2:0]  nbytes0,
  input  logic [2:0]  nbytes1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        mem_start,
  output logic [31:0] mem_addr,
  output logic        mem_is_write,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_nbytes,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_MASK =
    (ADDR_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ADDR_W) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        owner;
  logic [31:0] lat_addr;
  logic        lat_wr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_nbytes;

  logic        any_req;
  logic        pick;
  logic [31:0] sel_addr;
  logic        sel_wr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_nbytes;
  logic        sel_legal;

  assign any_req = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_ptr names the port that wins the next simultaneous request
  logic rr_ptr;

  always_comb begin
    if (req0 && req1) pick = rr_ptr;
    else              pick = ~req0;
  end
`else
  always_comb pick = ~req0;
`endif

  always_comb begin
    sel_addr   = pick ? addr1   : addr0;
    sel_wr     = pick ? wr1     : wr0;
    sel_wdata  = pick ? wdata1  : wdata0;
    sel_nbytes = pick ? nbytes1 : nbytes0;
    sel_legal  = (sel_nbytes == 3'd1) || (sel_nbytes == 3'd2) || (sel_nbytes == 3'd4);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (any_req) state_next = sel_legal ? S_ISSUE : S_RELEASE;
      S_ISSUE:   state_next = S_WAIT;
      S_WAIT:    if (mem_done) state_next = S_RELEASE;
      S_RELEASE: if (!mem_done) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wr     <= 1'b0;
      lat_wdata  <= 32'd0;
      lat_nbytes <= 3'd0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata      <= 32'd0;
      mem_start  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr     <= 1'b0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner      <= pick;
            lat_addr   <= sel_addr & ADDR_MASK;
            lat_wr     <= sel_wr;
            lat_wdata  <= sel_wdata;
            lat_nbytes <= sel_nbytes;
            gnt0       <= ~pick;
            gnt1       <= pick;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr     <= ~pick;
`endif
            // Illegal size completes at once without touching memory
            if (!sel_legal) begin
              done0 <= ~pick;
              done1 <= pick;
              err0  <= ~pick;
              err1  <= pick;
            end
          end
        end
        S_ISSUE: mem_start <= 1'b1;
        S_WAIT: begin
          if (mem_done) begin
            mem_start <= 1'b0;
            done0     <= ~owner;
            done1     <= owner;
            if (!lat_wr) rdata <= mem_rdata;
          end
        end
        S_RELEASE: begin
          if (!mem_done) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy         = (state != S_IDLE);
    mem_addr     = lat_addr;
    mem_is_write = lat_wr;
    mem_wdata    = lat_wdata;
    mem_nbytes   = lat_nbytes;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the test drives the memory engine's mem_done/mem_rdata by hand.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        wr0, wr1;
  logic [31:0] wdata0, wdata1;
  logic [2:0]  nbytes0, nbytes1;
  logic        done0, done1, err0, err1;
  logic [31:0] rdata;
  logic        gnt0, gnt1, busy;
  logic        mem_start;
  logic [31:0] mem_addr;
  logic        mem_is_write;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_nbytes;
  logic        mem_done;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wr0(wr0), .wr1(wr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .nbytes0(nbytes0), .nbytes1(nbytes1),
    .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .rdata(rdata),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .mem_start(mem_start), .mem_addr(mem_addr),
    .mem_is_write(mem_is_write), .mem_wdata(mem_wdata),
    .mem_nbytes(mem_nbytes),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef MEM_ARB_ROUND_ROBIN_EN
  int exp_order[5] = '{0, 1, 0, 1, 0};
`else
  int exp_order[5] = '{0, 0, 0, 0, 1};
`endif

  // One contended transfer: wait for a grant, run it, optionally let the served port re-request
  task automatic serve(input int idx, input int exp_who, input bit reassert);
    bit got;
    int who;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      if (gnt0 || gnt1) got = 1'b1;
    end
    check("ct_grant_seen", {31'd0, got}, 32'd1);
    if (!got) return;
    who = gnt1 ? 1 : 0;
    check("ct_one_gnt", {31'd0, gnt0 & gnt1}, 32'd0);
    check("ct_order", who, exp_who);
    tick();
    check("ct_start", {31'd0, mem_start}, 32'd1);
    mem_rdata = 32'h100 + idx;
    mem_done  = 1'b1;
    tick();
    check("ct_done", {31'd0, (who == 1) ? done1 : done0}, 32'd1);
    check("ct_rdata", rdata, 32'h100 + idx);
    if (who == 1) req1 = 1'b0; else req0 = 1'b0;
    mem_done = 1'b0;
    tick();
    if (reassert) begin
      if (who == 1) req1 = 1'b1; else req0 = 1'b1;
    end
  endtask

  initial begin
    bit gnt1_seen;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    nbytes0 = 0; nbytes1 = 0;
    mem_done = 0; mem_rdata = 0;

    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("rst_start", {31'd0, mem_start}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_done", {30'd0, done1, done0}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single read, port 0
    addr0 = 32'h0000_0010; nbytes0 = 3'd4; wr0 = 1'b0; req0 = 1'b1;
    gnt1_seen = 1'b0;
    tick();
    check("rd_gnt0", {31'd0, gnt0}, 32'd1);
    check("rd_start_early", {31'd0, mem_start}, 32'd0);
    check("rd_addr", mem_addr, 32'h0000_0010);
    check("rd_nbytes", {29'd0, mem_nbytes}, 32'd4);
    tick();
    check("rd_start", {31'd0, mem_start}, 32'd1);
    for (int k = 0; k < 38; k++) begin
      tick();
      if (gnt1) gnt1_seen = 1'b1;
    end
    check("rd_start_held", {31'd0, mem_start}, 32'd1);
    check("rd_no_done", {31'd0, done0}, 32'd0);
    mem_rdata = 32'hDEAD_BEEF; mem_done = 1'b1;
    tick();
    check("rd_done0", {31'd0, done0}, 32'd1);
    check("rd_err0", {31'd0, err0}, 32'd0);
    check("rd_rdata", rdata, 32'hDEAD_BEEF);
    check("rd_start_low", {31'd0, mem_start}, 32'd0);
    req0 = 1'b0; mem_done = 1'b0;
    tick();
    if (gnt1) gnt1_seen = 1'b1;
    check("rd_done_pulse", {31'd0, done0}, 32'd0);
    check("rd_gnt0_clear", {31'd0, gnt0}, 32'd0);
    check("rd_idle", {31'd0, busy}, 32'd0);
    check("rd_gnt1_never", {31'd0, gnt1_seen}, 32'd0);

    // Write, port 1
    addr1 = 32'h0000_1234; wr1 = 1'b1; wdata1 = 32'h0000_00A5; nbytes1 = 3'd1; req1 = 1'b1;
    tick();
    check("wr_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
    check("wr_is_write", {31'd0, mem_is_write}, 32'd1);
    check("wr_wdata", mem_wdata, 32'h0000_00A5);
    check("wr_nbytes", {29'd0, mem_nbytes}, 32'd1);
    check("wr_addr", mem_addr, 32'h0000_1234);
    tick();
    check("wr_start", {31'd0, mem_start}, 32'd1);
    mem_rdata = 32'h1111_1111; mem_done = 1'b1;
    tick();
    check("wr_done1", {30'd0, done1, done0}, 32'd2);
    check("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
    req1 = 1'b0; wr1 = 1'b0; mem_done = 1'b0;
    tick();

    // Illegal size; upper address bits must be masked off
    addr0 = 32'hFF00_0040; nbytes0 = 3'd3; req0 = 1'b1;
    tick();
    check("ill_done0", {31'd0, done0}, 32'd1);
    check("ill_err0", {31'd0, err0}, 32'd1);
    check("ill_gnt0", {31'd0, gnt0}, 32'd1);
    check("ill_start", {31'd0, mem_start}, 32'd0);
    check("ill_addr_mask", mem_addr, 32'h0000_0040);
    req0 = 1'b0;
    tick();
    check("ill_done_pulse", {30'd0, err0, done0}, 32'd0);
    check("ill_gnt_clear", {31'd0, gnt0}, 32'd0);
    check("ill_start2", {31'd0, mem_start}, 32'd0);
    tick();

    // Release: engine holds mem_done after done0, req1 pending meanwhile
    addr0 = 32'h0000_0020; nbytes0 = 3'd4; req0 = 1'b1;
    tick();
    check("rel_gnt0", {31'd0, gnt0}, 32'd1);
    addr1 = 32'h0000_0300; nbytes1 = 3'd2; wr1 = 1'b0; req1 = 1'b1;
    tick();
    mem_rdata = 32'h0BAD_F00D; mem_done = 1'b1;
    tick();
    check("rel_done0", {31'd0, done0}, 32'd1);
    req0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rel_hold_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    end
    mem_done = 1'b0;
    tick();
    check("rel_clear", {30'd0, gnt1, gnt0}, 32'd0);
    tick();
    check("rel_gnt1_next", {30'd0, gnt1, gnt0}, 32'd2);
    check("rel_addr1", mem_addr, 32'h0000_0300);
    tick();
    mem_rdata = 32'h00C0_FFEE; mem_done = 1'b1;
    tick();
    check("rel_done1", {31'd0, done1}, 32'd1);
    check("rel_rdata1", rdata, 32'h00C0_FFEE);
    req1 = 1'b0; mem_done = 1'b0;
    tick();

    // Reset mid-WAIT
    addr0 = 32'h0000_0044; nbytes0 = 3'd4; req0 = 1'b1;
    tick(); tick(); tick();
    check("mr_start_pre", {31'd0, mem_start}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("mr_start", {31'd0, mem_start}, 32'd0);
    check("mr_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_rdata", rdata, 32'd0);
    rst_n = 1'b1; req0 = 1'b0;
    tick();
    check("mr_no_done", {30'd0, done1, done0}, 32'd0);
    tick();

    // Contention, both ports requesting reads in the same cycle
    addr0 = 32'h0000_0500; nbytes0 = 3'd4; wr0 = 1'b0;
    addr1 = 32'h0000_0600; nbytes1 = 3'd4; wr1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 5; i++) serve(i, exp_order[i], i < 3);
    tick();
    check("ct_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares the single SPI external-memory engine (sclk/mosi/cs1/cs2 request/done interface) between requester 0 (CPU: instruction fetch and load/store) and requester 1 (debug/program-loader port). It sits between the requesters and the memory engine. It selects one request, holds the memory engine's start level and operands stable for the whole transfer, and returns read data with a one-cycle done pulse. It also performs the start/done release handshake so no requester has to.

## Interface
Parameters:
- ADDR_W, 24: significant address bits forwarded; upper bits of mem_addr driven 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req0 / req1  in  1  request; held high with operands stable until matching done pulse
- addr0 / addr1  in  32  byte address
- wr0 / wr1  in  1  1 = write, 0 = read
- wdata0 / wdata1  in  32  write value, right-aligned
- nbytes0 / nbytes1  in  3  transfer size; legal values 1, 2, 4
- done0 / done1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with done; 1 = illegal nbytes, memory not accessed
- rdata  out  32  read data of last completed read; valid from done onward
- gnt0 / gnt1  out  1  owner flag, high from issue through release
- busy  out  1  state != IDLE
- mem_start  out  1  start_request level to memory engine
- mem_addr  out  32  target_address
- mem_is_write  out  1
- mem_wdata  out  32
- mem_nbytes  out  3
- mem_done  in  1  request_done from memory engine, level
- mem_rdata  in  32  fetched_data

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE:
  - Sample req0/req1 and select a winner per Configuration.
  - Latch the winner's addr, wr, wdata and nbytes into registers. Set that port's gnt.
  - If nbytes is not in {1,2,4}, go to RELEASE with done=1 and err=1 for that port, mem_start stays 0. Otherwise go to ISSUE.
- ISSUE: drive mem_start=1 and the latched operands. Go to WAIT.
- WAIT:
  - Hold mem_start=1 and the operands.
  - On mem_done=1: capture mem_rdata into rdata (reads only; writes leave rdata unchanged), pulse done for the owner, drop mem_start, go to RELEASE.
- RELEASE:
  - Hold until mem_done=0, then clear gnt and return to IDLE.
  - Minimum one cycle, so the served requester's req is already low when IDLE next samples.
- mem_addr = {zeros, latched addr[ADDR_W-1:0]}. mem_* outputs hold their latched values outside WAIT/ISSUE; only mem_start is qualified.
- A req that drops before its done (protocol violation) is ignored. The transfer completes and done still pulses.
- Reset at any point, including mid-WAIT:
  - state IDLE; mem_start, gnt*, done*, err*, busy = 0; rdata, latched operands = 0; round-robin pointer favours port 0.
  - The memory engine is reset by the same rst_n.

## Timing
- req sampled in IDLE at cycle N → gnt and latched operands at N+1 → mem_start high at N+2.
- mem_done first seen high at cycle M → done pulse and rdata valid at M+1 → mem_start low at M+1.
- Illegal size: done and err at N+1; gnt clears once RELEASE sees mem_done=0.
- Minimum overhead per transfer: 3 cycles beyond the memory engine time.
- Back-to-back: a requester may reassert req in the cycle after done. The arbiter samples it in the next IDLE.
- Simultaneous req0 and req1 in IDLE: exactly one is granted. The loser keeps req high and is served next, by either rule, because the winner drops req.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - Simultaneous requests are granted to the port not served most recently. The 1-bit pointer updates on every grant.
  - After reset the pointer favours port 0.
- Undefined: fixed priority; port 0 always wins a simultaneous request, and there is no pointer register.
- A single request is granted immediately in both builds.

## Test plan
- Single read, port 0: addr0=0x000010, nbytes0=4, mem_rdata=0xDEADBEEF, mem_done after 40 cycles → mem_start high 2 cycles after req, done0 pulse 1 cycle, rdata=0xDEADBEEF, gnt1 never high.
- Write, port 1: wr1=1, wdata1=0x000000A5, nbytes1=1, addr1=0x1234 → mem_is_write=1, mem_wdata=0xA5, mem_nbytes=1, mem_addr=0x00001234; rdata unchanged; done1 pulse.
- Contention, both req high in the same cycle, two back-to-back transfers each:
  - Round-robin build: grant order 0,1,0,1.
  - Fixed build with req0 reasserted right after each done0: port 0 served repeatedly; port 1 starves until req0 stays low.
- Illegal size: nbytes0=3 → done0=1 and err0=1 one cycle after sampling; mem_start stays 0 throughout.
- Reset mid-WAIT: rst_n low for 1 cycle while mem_start=1 → next cycle state IDLE, mem_start=0, gnt*=0, rdata=0. No done pulse issued.
- Release: mem_done held high 3 cycles after done0 → gnt0 stays high until mem_done falls; a pending req1 is not sampled until the next IDLE.
